// File: rtl/wb_commit_arb_pkg.sv
// Shared widths and the writeback request record for the commit arbiter.
package wb_commit_arb_pkg;
  localparam int COMMIT_ID_WIDTH = 3;
  localparam int REG_ADDR_WIDTH  = 5;
  localparam int DATA_WIDTH      = 32;

  typedef struct packed {
    logic                       valid;
    logic [COMMIT_ID_WIDTH-1:0] id;
    logic                       rd_we;
    logic [REG_ADDR_WIDTH-1:0]  rd_addr;
    logic [DATA_WIDTH-1:0]      rd_data;
  } wb_req_t;

  // Register write happens only for enabled, non-x0 destinations.
  function automatic logic wb_writes(input wb_req_t r);
    return r.valid && r.rd_we && (r.rd_addr != '0);
  endfunction
endpackage

// File: rtl/wb_commit_arb_rr_pick2.sv
// Combinational round-robin picker: up to two one-hot grants scanning from ptr,
// plus the pointer value following the last grant.
module rr_pick2 #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt1,
  output logic [N-1:0]  gnt2,
  output logic          any1,
  output logic          any2,
  output logic [PW-1:0] idx1,
  output logic [PW-1:0] idx2,
  output logic [PW-1:0] next_ptr
);
  logic [PW-1:0] last;

  always_comb begin
    int k;
    k    = 0;
    gnt1 = '0;
    gnt2 = '0;
    any1 = 1'b0;
    any2 = 1'b0;
    idx1 = '0;
    idx2 = '0;
    for (int i = 0; i < N; i++) begin
      k = (int'(ptr) + i) % N;
      if (valid[k]) begin
        if (!any1) begin
          any1    = 1'b1;
          gnt1[k] = 1'b1;
          idx1    = PW'(k);
        end else if (!any2) begin
          any2    = 1'b1;
          gnt2[k] = 1'b1;
          idx2    = PW'(k);
        end
      end
    end
  end

  always_comb begin
    last     = any2 ? idx2 : idx1;
    next_ptr = ptr;
    if (any1) next_ptr = (last == PW'(N-1)) ? '0 : last + PW'(1);
  end
endmodule

// File: rtl/wb_commit_arb.sv
// Writeback/commit arbiter: retires up to two completions per cycle to the RF
// and hazard unit. Optional perf counters under WB_COMMIT_PERF_EN.
module wb_commit_arb
  import wb_commit_arb_pkg::*;
#(
  parameter int NUM_SRC = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_SRC-1:0]                 src_valid_i,
  output logic [NUM_SRC-1:0]                 src_ready_o,
  input  logic [NUM_SRC*COMMIT_ID_WIDTH-1:0] src_id_i,
  input  logic [NUM_SRC-1:0]                 src_rd_we_i,
  input  logic [NUM_SRC*REG_ADDR_WIDTH-1:0]  src_rd_addr_i,
  input  logic [NUM_SRC*DATA_WIDTH-1:0]      src_rd_data_i,
  output logic                               commit_valid_o,
  output logic [COMMIT_ID_WIDTH-1:0]         commit_id_o,
  output logic                               commit_valid2_o,
  output logic [COMMIT_ID_WIDTH-1:0]         commit_id2_o,
  output logic                               reg_we_o,
  output logic [REG_ADDR_WIDTH-1:0]          reg_waddr_o,
  output logic [DATA_WIDTH-1:0]              reg_wdata_o,
  output logic                               reg_we2_o,
  output logic [REG_ADDR_WIDTH-1:0]          reg_waddr2_o,
  output logic [DATA_WIDTH-1:0]              reg_wdata2_o
`ifdef WB_COMMIT_PERF_EN
  ,
  output logic [31:0]                        perf_commit_cnt_o,
  output logic [31:0]                        perf_conflict_cnt_o
`endif
);
  localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  wb_req_t       req [NUM_SRC];
  wb_req_t       s1, s2;
  logic [NUM_SRC-1:0] gnt1, gnt2;
  logic          any1, any2;
  logic [PW-1:0] idx1, idx2, rr_ptr, rr_nxt;

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_req
    assign req[k] = '{valid:   src_valid_i[k],
                      id:      src_id_i[k*COMMIT_ID_WIDTH +: COMMIT_ID_WIDTH],
                      rd_we:   src_rd_we_i[k],
                      rd_addr: src_rd_addr_i[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH],
                      rd_data: src_rd_data_i[k*DATA_WIDTH +: DATA_WIDTH]};
  end

  rr_pick2 #(.N(NUM_SRC), .PW(PW)) u_pick (
    .valid(src_valid_i), .ptr(rr_ptr), .gnt1(gnt1), .gnt2(gnt2),
    .any1(any1), .any2(any2), .idx1(idx1), .idx2(idx2), .next_ptr(rr_nxt)
  );

  // Grants are suppressed while reset is held so a completion is never lost.
  assign src_ready_o = rst_n ? (gnt1 | gnt2) : '0;
  assign s1 = req[idx1];
  assign s2 = req[idx2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr          <= '0;
      commit_valid_o  <= 1'b0;
      commit_id_o     <= '0;
      commit_valid2_o <= 1'b0;
      commit_id2_o    <= '0;
      reg_we_o        <= 1'b0;
      reg_waddr_o     <= '0;
      reg_wdata_o     <= '0;
      reg_we2_o       <= 1'b0;
      reg_waddr2_o    <= '0;
      reg_wdata2_o    <= '0;
    end else begin
      rr_ptr          <= rr_nxt;
      commit_valid_o  <= any1;
      commit_id_o     <= s1.id;
      commit_valid2_o <= any2;
      commit_id2_o    <= s2.id;
      reg_we_o        <= any1 && wb_writes(s1);
      reg_waddr_o     <= s1.rd_addr;
      reg_wdata_o     <= s1.rd_data;
      reg_we2_o       <= any2 && wb_writes(s2);
      reg_waddr2_o    <= s2.rd_addr;
      reg_wdata2_o    <= s2.rd_data;
    end
  end

  // Source protocol violations; there is no recovery path in hardware.
  always_ff @(posedge clk) begin
    if (rst_n && commit_valid_o && commit_valid2_o)
      assert (commit_id_o != commit_id2_o) else $error("duplicate commit id");
    if (rst_n && reg_we_o && reg_we2_o)
      assert (reg_waddr_o != reg_waddr2_o) else $error("same rd on both ports");
  end

`ifdef WB_COMMIT_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_commit_cnt_o   <= '0;
      perf_conflict_cnt_o <= '0;
    end else begin
      perf_commit_cnt_o <= perf_commit_cnt_o + 32'(any1) + 32'(any2);
      if ($countones(src_valid_i) > 2) perf_conflict_cnt_o <= perf_conflict_cnt_o + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_wb_commit_arb.sv
// Directed bench for wb_commit_arb; perf counter checks when WB_COMMIT_PERF_EN is set.
module tb_wb_commit_arb;
  localparam int N = 4, IW = 3, AW = 5, DW = 32;

  logic            clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0]    src_valid = '0, src_ready, src_we = '0;
  logic [N*IW-1:0] src_id = '0;
  logic [N*AW-1:0] src_addr = '0;
  logic [N*DW-1:0] src_data = '0;
  logic            cv, cv2, we, we2;
  logic [IW-1:0]   cid, cid2;
  logic [AW-1:0]   wa, wa2;
  logic [DW-1:0]   wd, wd2;
`ifdef WB_COMMIT_PERF_EN
  logic [31:0]     perf_commit, perf_conflict;
`endif
  int checks = 0, errors = 0;

  wb_commit_arb #(.NUM_SRC(N)) dut (
    .clk(clk), .rst_n(rst_n), .src_valid_i(src_valid), .src_ready_o(src_ready),
    .src_id_i(src_id), .src_rd_we_i(src_we), .src_rd_addr_i(src_addr), .src_rd_data_i(src_data),
    .commit_valid_o(cv), .commit_id_o(cid), .commit_valid2_o(cv2), .commit_id2_o(cid2),
    .reg_we_o(we), .reg_waddr_o(wa), .reg_wdata_o(wd),
    .reg_we2_o(we2), .reg_waddr2_o(wa2), .reg_wdata2_o(wd2)
`ifdef WB_COMMIT_PERF_EN
    , .perf_commit_cnt_o(perf_commit), .perf_conflict_cnt_o(perf_conflict)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int k, input logic [IW-1:0] id, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    src_valid[k] = 1'b1;
    src_id[k*IW +: IW] = id;
    src_we[k] = w;
    src_addr[k*AW +: AW] = a;
    src_data[k*DW +: DW] = d;
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_cv", cv, 0); chk("rst_cv2", cv2, 0); chk("rst_we", we, 0);
    chk("rst_wdata", wd, 0); chk("rst_ready", src_ready, 0);
    rst_n = 1'b1;
    tick();

    // Single source 2 (rr_ptr 0 -> 3)
    set_src(2, 3'd5, 1'b1, 5'd7, 32'hDEADBEEF);
    #1 chk("single_ready", src_ready, 4'b0100);
    tick(); src_valid = '0;
    chk("single_cv", cv, 1); chk("single_id", cid, 5); chk("single_we", we, 1);
    chk("single_waddr", wa, 7); chk("single_wdata", wd, 32'hDEADBEEF);
    chk("single_cv2", cv2, 0); chk("single_we2", we2, 0);
    tick();
    chk("idle_cv", cv, 0); chk("idle_we", we, 0);

    // Single source 3 wraps rr_ptr back to 0
    set_src(3, 3'd0, 1'b1, 5'd1, 32'h0);
    #1 chk("wrap_ready", src_ready, 4'b1000);
    tick(); src_valid = '0;
    chk("wrap_id", cid, 0);

    // Dual grant from rr_ptr 0
    set_src(0, 3'd1, 1'b1, 5'd3, 32'h1111);
    set_src(3, 3'd4, 1'b1, 5'd9, 32'h4444);
    #1 chk("dual_ready", src_ready, 4'b1001);
    tick(); src_valid = '0;
    chk("dual_cv", cv, 1); chk("dual_id", cid, 1); chk("dual_wa", wa, 3); chk("dual_wd", wd, 32'h1111);
    chk("dual_cv2", cv2, 1); chk("dual_id2", cid2, 4); chk("dual_wa2", wa2, 9);
    chk("dual_we2", we2, 1); chk("dual_wd2", wd2, 32'h4444);

    // Contention: all four valid, rr_ptr 0 -> {0,1},{2,3},{0,1},{2,3}
    for (int k = 0; k < N; k++) set_src(k, IW'(k), 1'b1, AW'(k + 10), DW'(k));
    for (int c = 0; c < 4; c++) begin
      #1 chk("cont_ready", src_ready, (c % 2 == 0) ? 4'b0011 : 4'b1100);
      tick();
      chk("cont_id", cid, (c % 2 == 0) ? 0 : 2);
      chk("cont_id2", cid2, (c % 2 == 0) ? 1 : 3);
      chk("cont_wa2", wa2, (c % 2 == 0) ? 11 : 13);
    end
    src_valid = '0;

    // x0 write and no-write still commit; rr_ptr 0
    set_src(1, 3'd6, 1'b1, 5'd0, 32'hAAAA);
    set_src(2, 3'd2, 1'b0, 5'd5, 32'hBBBB);
    #1 chk("x0_ready", src_ready, 4'b0110);
    tick(); src_valid = '0;
    chk("x0_cv", cv, 1); chk("x0_id", cid, 6); chk("x0_we", we, 0);
    chk("x0_cv2", cv2, 1); chk("x0_id2", cid2, 2); chk("x0_we2", we2, 0);

    // Async reset mid-cycle; rr_ptr 3 -> grants {0,1} -> rr_ptr 2
    for (int k = 0; k < 3; k++) set_src(k, IW'(k), 1'b1, AW'(k + 20), DW'(k));
    #1 chk("pre_rst_ready", src_ready, 4'b0011);
    tick();
    chk("pre_rst_cv", cv, 1);
    chk("pre_rst_ready2", src_ready, 4'b0101);
    #2 rst_n = 1'b0;
    #1 chk("arst_cv", cv, 0); chk("arst_cv2", cv2, 0); chk("arst_we", we, 0);
    chk("arst_wa", wa, 0); chk("arst_ready", src_ready, 0);
    rst_n = 1'b1;
    #1 chk("post_rst_ready", src_ready, 4'b0011);
    tick(); src_valid = '0;
    chk("post_rst_id", cid, 0); chk("post_rst_id2", cid2, 1);

`ifdef WB_COMMIT_PERF_EN
    // Counters from reset: 10 cycles of three continuously valid sources
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) set_src(k, IW'(k), 1'b1, AW'(k + 1), DW'(k));
    for (int c = 0; c < 10; c++) tick();
    src_valid = '0;
    chk("perf_commit", perf_commit, 20);
    chk("perf_conflict", perf_conflict, 10);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
